// File: rtl/bias_buf_if.sv
// Bundle of the load-stream and group-read signals of the bias buffer.
// master = loader/consumer side, slave = bias_buf_ctrl.
interface bias_buf_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int NUM_CH = 4
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic                     load_start;
  logic [ADDR_W:0]          load_len;
  logic                     in_valid;
  logic [DATA_W-1:0]        in_data;
  logic                     in_ready;
  logic                     load_done;
  logic                     busy;
  logic                     rd_req;
  logic [ADDR_W-1:0]        rd_addr;
  logic                     rd_valid;
  logic [NUM_CH*DATA_W-1:0] rd_data;
  logic [NUM_CH-1:0]        rd_par_err;

  modport master (
    output load_start, load_len, in_valid, in_data, rd_req, rd_addr,
    input  in_ready, load_done, busy, rd_valid, rd_data, rd_par_err
  );

  modport slave (
    input  load_start, load_len, in_valid, in_data, rd_req, rd_addr,
    output in_ready, load_done, busy, rd_valid, rd_data, rd_par_err
  );
endinterface

// File: rtl/bias_buf_ctrl.sv
// Multi-channel bias buffer: streams words round-robin into NUM_CH banks, serves one group per read.
// Build macro BIAS_PARITY_EN adds per-entry even parity and per-bank read error flags.
module bias_buf_ctrl #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int NUM_CH = 4
) (
  input logic       clk,
  input logic       rst,
  bias_buf_if.slave bus
);
  // state | meaning
  // IDLE  | waiting; load_start and rd_req honoured
  // LOAD  | accepting stream words into banks
  // DONE  | single-cycle load_done pulse
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int RD_W   = NUM_CH * DATA_W;
`ifdef BIAS_PARITY_EN
  localparam int ENT_W  = DATA_W + 1;
`else
  localparam int ENT_W  = DATA_W;
`endif
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   ch_cnt_q, ch_cnt_d;
  logic [ADDR_W-1:0] grp_cnt_q, grp_cnt_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   len_clamped;
  logic              accept;
  logic              last_word;
  logic              rd_fire;
  logic              rd_in_range;
  logic [ENT_W-1:0]  wr_entry;

  logic [ENT_W-1:0]  mem_q [NUM_CH][DEPTH];

  logic [RD_W-1:0]   rd_data_q, rd_data_d;
  logic              rd_valid_q;

  always_comb begin
    len_clamped = (bus.load_len > DEPTH_L) ? DEPTH_L : bus.load_len;
    accept      = (state_q == LOAD) && bus.in_valid;
    last_word   = ({1'b0, grp_cnt_q} == (len_q - 1'b1)) && (ch_cnt_q == CH_LAST);
  end

  always_comb begin
    state_d   = state_q;
    ch_cnt_d  = ch_cnt_q;
    grp_cnt_d = grp_cnt_q;
    len_d     = len_q;
    case (state_q)
      IDLE: begin
        ch_cnt_d  = '0;
        grp_cnt_d = '0;
        if (bus.load_start) begin
          len_d   = len_clamped;
          state_d = (len_clamped == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          if (last_word) state_d = DONE;
          if (ch_cnt_q == CH_LAST) begin
            ch_cnt_d  = '0;
            grp_cnt_d = grp_cnt_q + 1'b1;
          end else begin
            ch_cnt_d  = ch_cnt_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ch_cnt_q  <= '0;
      grp_cnt_q <= '0;
      len_q     <= '0;
    end else begin
      state_q   <= state_d;
      ch_cnt_q  <= ch_cnt_d;
      grp_cnt_q <= grp_cnt_d;
      len_q     <= len_d;
    end
  end

`ifdef BIAS_PARITY_EN
  assign wr_entry = {^bus.in_data, bus.in_data};
`else
  assign wr_entry = bus.in_data;
`endif

  // Bank storage is deliberately left out of reset so a mid-load reset keeps written words.
  always_ff @(posedge clk) begin
    if (accept) mem_q[ch_cnt_q][grp_cnt_q] <= wr_entry;
  end

  always_comb begin
    rd_fire     = bus.rd_req && (state_q == IDLE);
    rd_in_range = ({1'b0, bus.rd_addr} < DEPTH_L);
    rd_data_d   = rd_data_q;
    if (rd_fire) begin
      rd_data_d = '0;
      if (rd_in_range) begin
        for (int k = 0; k < NUM_CH; k++) begin
          rd_data_d[k*DATA_W +: DATA_W] = mem_q[k][bus.rd_addr][DATA_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_fire;
      rd_data_q  <= rd_data_d;
    end
  end

`ifdef BIAS_PARITY_EN
  logic [NUM_CH-1:0] rd_par_err_q, rd_par_err_d;

  always_comb begin
    rd_par_err_d = rd_par_err_q;
    if (rd_fire) begin
      rd_par_err_d = '0;
      if (rd_in_range) begin
        for (int k = 0; k < NUM_CH; k++) begin
          rd_par_err_d[k] = ^mem_q[k][bus.rd_addr];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rd_par_err_q <= '0;
    else     rd_par_err_q <= rd_par_err_d;
  end

  assign bus.rd_par_err = rd_par_err_q;
`else
  assign bus.rd_par_err = '0;
`endif

  assign bus.in_ready  = (state_q == LOAD);
  assign bus.busy      = (state_q == LOAD);
  assign bus.load_done = (state_q == DONE);
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
endmodule

// File: tb/tb_bias_buf_ctrl.sv
// Self-checking bench for bias_buf_ctrl: randomized loads/reads against a bank-array model.
// Build with BIAS_PARITY_EN defined to also exercise the parity error path.
module tb_bias_buf_ctrl;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;
  localparam int NUM_CH = 4;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int RD_W   = NUM_CH * DATA_W;

  logic clk = 1'b0;
  logic rst = 1'b1;

  bias_buf_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_CH(NUM_CH)) bus ();

  bias_buf_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_CH(NUM_CH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // model[bank][group] mirrors what each accepted stream word should have become
  logic [DATA_W-1:0] model [NUM_CH][DEPTH];
  logic [RD_W-1:0]   last_rd;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [RD_W-1:0] exp_row(input int a);
    logic [RD_W-1:0] r;
    for (int k = 0; k < NUM_CH; k++) r[k*DATA_W +: DATA_W] = model[k][a];
    return r;
  endfunction

  task automatic do_read(input int a, input string tag);
    logic [RD_W-1:0] e;
    e = exp_row(a);
    bus.rd_req  = 1'b1;
    bus.rd_addr = a[ADDR_W-1:0];
    tick();
    bus.rd_req  = 1'b0;
    n_checks++;
    if (bus.rd_valid !== 1'b1) begin n_fail++; $display("FAIL %s rd_valid a=%0d: got %b want 1", tag, a, bus.rd_valid); end
    n_checks++;
    if (bus.rd_data !== e) begin n_fail++; $display("FAIL %s rd_data a=%0d: got %h want %h", tag, a, bus.rd_data, e); end
    n_checks++;
    if (bus.rd_par_err !== '0) begin n_fail++; $display("FAIL %s rd_par_err a=%0d: got %b want 0", tag, a, bus.rd_par_err); end
    last_rd = e;
    tick();
    n_checks++;
    if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL %s rd_valid_drop: got %b want 0", tag, bus.rd_valid); end
    n_checks++;
    if (bus.rd_data !== e) begin n_fail++; $display("FAIL %s rd_data_hold: got %h want %h", tag, bus.rd_data, e); end
  endtask

  // stall_pct < 0 selects a strict 1/0 toggle of in_valid
  task automatic run_load(input int len, input int stall_pct, input bit seq,
                          input bit rd_during, input bit rd_at_start, input string tag);
    int eff, total, acc, cyc;
    logic v;
    logic [RD_W-1:0] pre;
    eff   = (len > DEPTH) ? DEPTH : len;
    total = eff * NUM_CH;
    pre   = exp_row(0);
    bus.load_start = 1'b1;
    bus.load_len   = len[ADDR_W:0];
    bus.rd_req     = rd_at_start;
    bus.rd_addr    = '0;
    tick();
    bus.load_start = 1'b0;
    bus.rd_req     = 1'b0;
    if (rd_at_start) begin
      n_checks++;
      if (bus.rd_valid !== 1'b1) begin n_fail++; $display("FAIL %s start_rd_valid: got %b want 1", tag, bus.rd_valid); end
      n_checks++;
      if (bus.rd_data !== pre) begin n_fail++; $display("FAIL %s start_rd_data: got %h want %h", tag, bus.rd_data, pre); end
      last_rd = pre;
    end
    n_checks++;
    if (bus.busy !== (eff > 0)) begin n_fail++; $display("FAIL %s busy_start: got %b want %b", tag, bus.busy, eff > 0); end
    acc = 0;
    cyc = 0;
    while (acc < total && cyc < 4000) begin
      v = (stall_pct < 0) ? ((cyc % 2) == 0) : ($urandom_range(99) >= stall_pct);
      n_checks++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL %s in_ready acc=%0d: got %b want 1", tag, acc, bus.in_ready); end
      n_checks++;
      if (bus.load_done !== 1'b0) begin n_fail++; $display("FAIL %s early_done acc=%0d: got %b want 0", tag, acc, bus.load_done); end
      bus.in_valid = v;
      bus.in_data  = seq ? DATA_W'(acc + 1) : DATA_W'($urandom);
      bus.rd_req   = rd_during;
      bus.rd_addr  = ADDR_W'($urandom);
      tick();
      if (rd_during) begin
        n_checks++;
        if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL %s rd_in_load: got %b want 0", tag, bus.rd_valid); end
        n_checks++;
        if (bus.rd_data !== last_rd) begin n_fail++; $display("FAIL %s rd_hold_load: got %h want %h", tag, bus.rd_data, last_rd); end
      end
      if (v) begin
        model[acc % NUM_CH][acc / NUM_CH] = bus.in_data;
        acc++;
      end
      cyc++;
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (acc != total) begin n_fail++; $display("FAIL %s timeout: accepted %0d want %0d", tag, acc, total); end
    n_checks++;
    if (bus.load_done !== 1'b1) begin n_fail++; $display("FAIL %s load_done: got %b want 1", tag, bus.load_done); end
    n_checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL %s busy_in_done: got busy=%b in_ready=%b want 0/0", tag, bus.busy, bus.in_ready);
    end
    bus.rd_req = rd_during;
    tick();
    bus.rd_req = 1'b0;
    n_checks++;
    if (bus.load_done !== 1'b0) begin n_fail++; $display("FAIL %s done_width: got %b want 0", tag, bus.load_done); end
    if (rd_during) begin
      n_checks++;
      if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL %s rd_in_done: got %b want 0", tag, bus.rd_valid); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (bus.in_ready !== 1'b0 || bus.load_done !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got ready=%b done=%b busy=%b want 0", bus.in_ready, bus.load_done, bus.busy);
    end
    n_checks++;
    if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b want 0", bus.rd_valid); end
    n_checks++;
    if (bus.rd_data !== '0) begin n_fail++; $display("FAIL reset_rd_data: got %h want 0", bus.rd_data); end
    n_checks++;
    if (bus.rd_par_err !== '0) begin n_fail++; $display("FAIL reset_par_err: got %b want 0", bus.rd_par_err); end
    last_rd = '0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_clamp();
    run_load(31, 20, 1'b0, 1'b0, 1'b0, "clamp");
    for (int a = 0; a < DEPTH; a++) do_read((a * 7) % DEPTH, "clamp_rd");
  endtask

  task automatic test_basic();
    logic [RD_W-1:0] k0;
    k0 = 64'h0004_0003_0002_0001;
    run_load(2, 0, 1'b1, 1'b0, 1'b0, "basic");
    do_read(0, "basic_rd0");
    n_checks++;
    if (bus.rd_data !== k0) begin n_fail++; $display("FAIL basic_const: got %h want %h", bus.rd_data, k0); end
    do_read(1, "basic_rd1");
  endtask

  task automatic test_stall();
    logic [RD_W-1:0] k1;
    k1 = 64'h0008_0007_0006_0005;
    run_load(2, 0, 1'b0, 1'b0, 1'b0, "scramble");
    run_load(2, -1, 1'b1, 1'b0, 1'b0, "toggle");
    do_read(0, "toggle_rd0");
    do_read(1, "toggle_rd1");
    n_checks++;
    if (bus.rd_data !== k1) begin n_fail++; $display("FAIL toggle_const: got %h want %h", bus.rd_data, k1); end
  endtask

  task automatic test_zero_len();
    run_load(0, 0, 1'b0, 1'b0, 1'b0, "zero");
    do_read(0, "zero_rd");
  endtask

  task automatic test_reset_mid_load();
    bus.load_start = 1'b1;
    bus.load_len   = (ADDR_W+1)'(2);
    tick();
    bus.load_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = DATA_W'($urandom);
      tick();
      model[i][0] = bus.in_data;
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.load_done !== 1'b0) begin
      n_fail++; $display("FAIL midrst_state: got busy=%b done=%b want 0/0", bus.busy, bus.load_done);
    end
    last_rd = '0;
    tick();
    n_checks++;
    if (bus.load_done !== 1'b0) begin n_fail++; $display("FAIL midrst_no_done: got %b want 0", bus.load_done); end
    do_read(0, "midrst_rd");
  endtask

  task automatic test_back_to_back();
    run_load(1, 30, 1'b0, 1'b1, 1'b0, "rd_during");
    run_load(1, 0, 1'b0, 1'b0, 1'b1, "start_rd");
    do_read(0, "start_rd_after");
  endtask

  task automatic test_parity();
`ifdef BIAS_PARITY_EN
    logic [NUM_CH-1:0] pe;
    pe = 4'b0100;
    dut.mem_q[2][1][0] = ~dut.mem_q[2][1][0];
    model[2][1][0]     = ~model[2][1][0];
    bus.rd_req  = 1'b1;
    bus.rd_addr = ADDR_W'(1);
    tick();
    bus.rd_req  = 1'b0;
    n_checks++;
    if (bus.rd_par_err !== pe) begin n_fail++; $display("FAIL parity_err: got %b want %b", bus.rd_par_err, pe); end
    n_checks++;
    if (bus.rd_data !== exp_row(1)) begin n_fail++; $display("FAIL parity_data: got %h want %h", bus.rd_data, exp_row(1)); end
    last_rd = exp_row(1);
    tick();
    dut.mem_q[2][1][0] = ~dut.mem_q[2][1][0];
    model[2][1][0]     = ~model[2][1][0];
`endif
    do_read(1, "parity_clean");
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      run_load($urandom_range(20), $urandom_range(60), 1'b0, 1'b0, 1'b0, "rand");
      for (int r = 0; r < 4; r++) do_read($urandom_range(DEPTH - 1), "rand_rd");
    end
  endtask

  initial begin
    bus.load_start = 1'b0;
    bus.load_len   = '0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.rd_req     = 1'b0;
    bus.rd_addr    = '0;
    test_reset();
    test_clamp();
    test_basic();
    test_stall();
    test_zero_len();
    test_reset_mid_load();
    test_back_to_back();
    test_parity();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
